// File: rtl/elastic_pipe_stage.sv
// DEPTH-stage valid/ready register chain with bubble collapsing and partial
// flush of the youngest stages. Stage 0 is youngest, stage DEPTH-1 drives out.

module elastic_pipe_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  input  logic              src_live,
  input  logic [DATA_W-1:0] src_data,
  input  logic              kill_self,
  output logic              v,
  output logic [DATA_W-1:0] d
);
  // A held item that falls inside the flush window is dropped in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      if (adv)            v <= src_live;
      else if (kill_self) v <= 1'b0;
      if (adv && src_live) d <= src_data;
    end
  end
endmodule

module elastic_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush_i,
  input  logic [CW-1:0]     flush_depth_i,
  output logic [DEPTH-1:0]  stage_valid_o,
  output logic [CW-1:0]     count_o
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0]             v, rdy, kill;
  logic [DEPTH-1:0][DATA_W-1:0] d;
  logic [CW-1:0]                kf, killed;
  logic                         in_fire, out_fire;

  assign kf = !flush_i ? '0 : (flush_depth_i > DEPTH_C) ? DEPTH_C : flush_depth_i;

  // rdy[i] is the flattened ready chain: any bubble at or above i, or a drain.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ctl
      assign rdy[gi]  = out_ready | ~(&v[DEPTH-1:gi]);
      assign kill[gi] = CW'(gi) < kf;
    end
  endgenerate

  assign in_ready  = rdy[0] & (kf == '0);
  assign out_valid = v[DEPTH-1] & (kf != DEPTH_C);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = d[DEPTH-1];
  assign stage_valid_o = v;

  always_comb begin
    killed = '0;
    for (int i = 0; i < DEPTH; i++)
      killed = killed + CW'(v[i] & kill[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) count_o <= '0;
    else       count_o <= count_o + CW'(in_fire) - CW'(out_fire) - killed;
  end

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic              src_live;
      logic [DATA_W-1:0] src_data;
      if (gi == 0) begin : g_head
        assign src_live = in_fire;
        assign src_data = in_data;
      end else begin : g_body
        assign src_live = v[gi-1] & ~kill[gi-1];
        assign src_data = d[gi-1];
      end
      elastic_pipe_slot #(.DATA_W(DATA_W)) u_slot (
        .clk      (clk),
        .reset    (reset),
        .adv      (rdy[gi]),
        .src_live (src_live),
        .src_data (src_data),
        .kill_self(kill[gi]),
        .v        (v[gi]),
        .d        (d[gi])
      );
    end
  endgenerate
endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Directed bench: per-cycle comparison against a slot-occupancy model plus
// literal expectations for each scenario.

module tb_elastic_pipe_stage;
  localparam int DW = 32;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, out_valid, out_ready, flush_i;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] flush_depth_i, count_o;
  logic [D-1:0]  stage_valid_o;

  elastic_pipe_stage #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush_i(flush_i), .flush_depth_i(flush_depth_i),
    .stage_valid_o(stage_valid_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: which slots hold an item, what each holds, last payload to reach the output slot
  bit            mv[D];
  logic [DW-1:0] md[D];
  logic [DW-1:0] mout;
  logic [DW-1:0] outq[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit can_adv(input int i);
    bit r;
    r = out_ready;
    for (int j = i; j < D; j++) if (!mv[j]) r = 1'b1;
    return r;
  endfunction

  task automatic drive(input bit rst, input bit iv, input logic [DW-1:0] id,
                       input bit ordy, input bit fl, input logic [CW-1:0] k);
    reset = rst; in_valid = iv; in_data = id; out_ready = ordy;
    flush_i = fl; flush_depth_i = k;
    #1;
  endtask

  task automatic step();
    int            kf, cnt;
    bit            e_ir, e_ov;
    bit            nv[D];
    logic [DW-1:0] nd[D];
    logic [D-1:0]  e_sv;
    @(negedge clk);
    kf = !flush_i ? 0 : (int'(flush_depth_i) > D ? D : int'(flush_depth_i));
    e_ir = (kf == 0) && can_adv(0);
    e_ov = mv[D-1] && (kf != D);
    cnt = 0;
    for (int i = 0; i < D; i++) begin
      e_sv[i] = mv[i];
      cnt += int'(mv[i]);
    end
    chk("in_ready", in_ready, e_ir);
    chk("out_valid", out_valid, e_ov);
    chk("out_data", out_data, mout);
    chk("stage_valid", stage_valid_o, e_sv);
    chk("count", count_o, cnt);
    if (out_valid && out_ready) outq.push_back(out_data);
    for (int i = 0; i < D; i++) begin nv[i] = 1'b0; nd[i] = md[i]; end
    if (reset) begin
      mout = '0;
      for (int i = 0; i < D; i++) nd[i] = '0;
    end else begin
      for (int i = D-1; i >= 0; i--) begin
        if (mv[i] && i >= kf) begin
          if (i == D-1) begin
            if (!out_ready) nv[i] = 1'b1;
          end else if (can_adv(i+1)) begin
            nv[i+1] = 1'b1; nd[i+1] = md[i];
            if (i+1 == D-1) mout = md[i];
          end else nv[i] = 1'b1;
        end
      end
      if (in_valid && e_ir) begin nv[0] = 1'b1; nd[0] = in_data; end
    end
    for (int i = 0; i < D; i++) begin mv[i] = nv[i]; md[i] = nd[i]; end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    repeat (n) begin drive(0, 0, '0, ordy, 0, 0); step(); end
  endtask

  task automatic fill4(input logic [DW-1:0] base);
    for (int i = 1; i <= D; i++) begin drive(0, 1, base + i, 0, 0, 0); step(); end
  endtask

  task automatic chk_q(input string name, input logic [DW-1:0] exp[$]);
    chk({name, "_len"}, outq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < outq.size(); i++) chk(name, outq[i], exp[i]);
  endtask

  initial begin
    int n;
    mout = '0;
    for (int i = 0; i < D; i++) begin mv[i] = 1'b0; md[i] = '0; end

    // reset
    drive(1, 0, '0, 0, 0, 0); step(); step();
    chk("rst_sv", stage_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_out_data", out_data, 0);
    drive(0, 0, '0, 0, 0, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);

    // streaming 1..8
    outq.delete();
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, i, 1, 0, 0); step();
      if (i == 3) chk("lat_not_yet", out_valid, 0);
      if (i == 4) begin chk("lat_first", out_valid, 1); chk("lat_data", out_data, 1); end
      if (i >= 4) chk("stream_count", count_o, 4);
    end
    idle(6, 1);
    chk_q("stream_out", '{1, 2, 3, 4, 5, 6, 7, 8});

    // back-pressure
    outq.delete();
    n = 1;
    repeat (6) begin
      drive(0, 1, 'h10 + n, 0, 0, 0);
      if (in_ready) n++;
      step();
    end
    drive(0, 1, 'h10 + n, 0, 0, 0);
    chk("bp_accepted", n - 1, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_sv", stage_valid_o, 4'b1111);
    chk("bp_count", count_o, 4);
    drive(0, 1, 'h10 + n, 1, 0, 0);
    chk("bp_release", in_ready, 1);
    repeat (12) begin
      drive(0, n <= 6, 'h10 + n, 1, 0, 0);
      if (in_valid && in_ready) n++;
      step();
    end
    chk_q("bp_out", '{'h11, 'h12, 'h13, 'h14, 'h15, 'h16});

    // bubble collapse
    outq.delete();
    drive(0, 1, 'hA, 0, 0, 0); step();
    idle(2, 0);
    drive(0, 1, 'hB, 0, 0, 0); step();
    idle(3, 0);
    chk("bub_sv", stage_valid_o, 4'b1100);
    chk("bub_out", out_data, 'hA);
    chk("bub_count", count_o, 2);
    idle(4, 1);
    chk_q("bub_drain", '{'hA, 'hB});

    // partial flush K=2, stalled
    outq.delete();
    fill4(0);
    drive(0, 1, 'h99, 0, 1, 2);
    chk("pf_in_ready", in_ready, 0);
    step();
    chk("pf_sv", stage_valid_o, 4'b1100);
    chk("pf_count", count_o, 2);
    idle(5, 1);
    chk_q("pf_drain", '{1, 2});

    // partial flush K=1 with concurrent out fire
    outq.delete();
    fill4('h40);
    drive(0, 0, '0, 1, 1, 1);
    chk("pfo_out_valid", out_valid, 1);
    step();
    chk("pfo_count", count_o, 2);
    chk("pfo_sv", stage_valid_o, 4'b1100);
    idle(4, 1);
    chk_q("pfo_drain", '{'h41, 'h42, 'h43});

    // full flush with traffic, K=4 then K=7 (clamped)
    for (int k = 4; k <= 7; k += 3) begin
      outq.delete();
      fill4('h50);
      drive(0, 1, 'h55, 1, 1, k[CW-1:0]);
      chk("ff_out_valid", out_valid, 0);
      chk("ff_in_ready", in_ready, 0);
      step();
      chk("ff_count", count_o, 0);
      chk("ff_sv", stage_valid_o, 0);
      idle(3, 1);
      chk("ff_no_out", outq.size(), 0);
    end

    // reset mid-stream
    for (int i = 1; i <= 6; i++) begin drive(0, 1, 'h20 + i, 1, 0, 0); step(); end
    drive(1, 1, 'h30, 1, 1, 2); step();
    outq.delete();
    drive(0, 0, '0, 1, 0, 0);
    chk("mrst_count", count_o, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_in_ready", in_ready, 1);
    idle(6, 1);
    chk("mrst_no_stale", outq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
